// File: rtl/board_disp_pkg.sv
// Shared types and helpers for the serial display driver.
package board_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_e;

    // Bits needed to hold values 0..v-1 (at least one bit).
    function automatic int unsigned clog2w(input int unsigned v);
        int unsigned r;
        r = 32'd1;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 32'd1;
        end
        return r;
    endfunction

    // Hex nibble to active-high gfedcba segment pattern.
    function automatic logic [6:0] seg_enc(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/board_disp_serial_if.sv
// Register-side inputs and board-pin outputs of the display driver.
// The one-cycle refresh request is named force_req because "force" is reserved.
interface board_disp_serial_if #(
    parameter int DIGITS   = 8,
    parameter int LED_BITS = 16
);
    logic [DIGITS-1:0]   en;
    logic                mode;
    logic [4*DIGITS-1:0] data_text;
    logic [8*DIGITS-1:0] data_graphic;
    logic [DIGITS-1:0]   dot;
    logic [DIGITS-1:0]   blink;
    logic [LED_BITS-1:0] led;
    logic                force_req;
    logic                busy;
    logic                frame_done;
    logic                led_clk;
    logic                led_do;
    logic                led_en;
    logic                seg_clk;
    logic                seg_do;
    logic                seg_en;

    modport master (
        output en, mode, data_text, data_graphic, dot, blink, led, force_req,
        input  busy, frame_done, led_clk, led_do, led_en, seg_clk, seg_do, seg_en
    );

    modport slave (
        input  en, mode, data_text, data_graphic, dot, blink, led, force_req,
        output busy, frame_done, led_clk, led_do, led_en, seg_clk, seg_do, seg_en
    );
endinterface

// File: rtl/board_disp_serial_shift_chan.sv
// One serial output channel: snapshots a frame and shifts it out MSB-first.
// All strobes describe the NEXT cycle so that clock, data and enable are flops.
module disp_shift_chan #(
    parameter int LEN    = 16,
    parameter bit INVERT = 1'b0,
    parameter int SW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [LEN-1:0] frame,
    input  logic          slot_adv,
    input  logic [SW-1:0] nxt_slot,
    input  logic          shift_nxt,
    input  logic          clk_hi_nxt,
    output logic          sclk,
    output logic          sdo,
    output logic          soe
);
    logic [LEN-1:0] sr_r;
    logic [LEN-1:0] frame_x_s;
    logic           in_len_s;
    logic           sclk_r;
    logic           sdo_r;
    logic           soe_r;

    assign frame_x_s = frame ^ {LEN{INVERT}};
    assign in_len_s  = (nxt_slot < SW'(LEN));

    // Load places the MSB on the pin at once; each later slot start shifts the next bit out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r   <= '0;
            sdo_r  <= 1'b0;
            sclk_r <= 1'b0;
            soe_r  <= 1'b0;
        end else begin
            soe_r  <= !shift_nxt;
            sclk_r <= shift_nxt && clk_hi_nxt && in_len_s;
            if (load) begin
                sdo_r <= frame_x_s[LEN-1];
                sr_r  <= frame_x_s << 1;
            end else if (slot_adv && in_len_s) begin
                sdo_r <= sr_r[LEN-1];
                sr_r  <= sr_r << 1;
            end else begin
                sdo_r <= sdo_r;
                sr_r  <= sr_r;
            end
        end
    end

    assign sclk = sclk_r;
    assign sdo  = sdo_r;
    assign soe  = soe_r;
endmodule

// File: rtl/board_disp_serial.sv
// Serial LED-bar / 7-segment driver: frame builder, refresh timing and
// transfer FSM; the two channels share one slot/phase sequencer.
module board_disp_serial
    import board_disp_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int LED_BITS       = 16,
    parameter int SCLK_DIV       = 6,
    parameter int REFRESH_CYCLES = 10_000_000,
    parameter int BLINK_TICKS    = 5,
    parameter bit SEG_INVERT     = 1'b0,
    parameter bit LED_INVERT     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    board_disp_serial_if.slave bus
);
    localparam int SEG_BITS = 8 * DIGITS;
    localparam int NBITS    = (SEG_BITS > LED_BITS) ? SEG_BITS : LED_BITS;
    localparam int PH_W     = clog2w(SCLK_DIV);
    localparam int SLOT_W   = clog2w(NBITS + 1);
    localparam int REF_W    = clog2w(REFRESH_CYCLES);
    localparam int BL_W     = clog2w(BLINK_TICKS);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(SCLK_DIV / 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NBITS - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [BL_W-1:0]   BL_LAST   = BL_W'(BLINK_TICKS - 1);

    disp_state_e         state_r, nxt_state_s;
    logic [PH_W-1:0]     ph_r, nxt_ph_s;
    logic [SLOT_W-1:0]   slot_r, nxt_slot_s;
    logic [REF_W-1:0]    refr_cnt_r;
    logic [BL_W-1:0]     blink_cnt_r;
    logic                blink_ph_r;
    logic                pend_r;
    logic                busy_r;
    logic                done_r;
    logic                tick_s, req_s, load_s, slot_adv_s, shift_nxt_s, clk_hi_nxt_s;
    logic [SEG_BITS-1:0] seg_frame_s;
    logic [7:0]          tube_s;
    logic                seg_clk_s, seg_do_s, seg_en_s, led_clk_s, led_do_s, led_en_s;

    assign tick_s       = (refr_cnt_r == REF_LAST);
    assign req_s        = tick_s || bus.force_req;
    assign load_s       = (state_r == ST_LOAD);
    assign shift_nxt_s  = (nxt_state_s == ST_SHIFT);
    assign clk_hi_nxt_s = (nxt_ph_s >= PH_HALF);
    assign slot_adv_s   = (state_r == ST_SHIFT) && (ph_r == PH_LAST) && (slot_r != SLOT_LAST);

    // Free-running refresh counter and blink phase, which advances on ticks only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refr_cnt_r  <= '0;
            blink_cnt_r <= '0;
            blink_ph_r  <= 1'b1;
        end else if (tick_s) begin
            refr_cnt_r <= '0;
            if (blink_cnt_r == BL_LAST) begin
                blink_cnt_r <= '0;
                blink_ph_r  <= ~blink_ph_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BL_W'(1);
                blink_ph_r  <= blink_ph_r;
            end
        end else begin
            refr_cnt_r  <= refr_cnt_r + REF_W'(1);
            blink_cnt_r <= blink_cnt_r;
            blink_ph_r  <= blink_ph_r;
        end
    end

    // A request while busy is remembered once; a new request in LOAD wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
        end else if (req_s && (state_r != ST_IDLE)) begin
            pend_r <= 1'b1;
        end else if (state_r == ST_LOAD) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    // Segment frame: text/graphic select, tube enable, then blink blanking.
    always_comb begin
        seg_frame_s = '0;
        tube_s      = 8'h00;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.mode) begin
                tube_s = bus.en[i] ? bus.data_graphic[8*i +: 8] : 8'h00;
            end else begin
                tube_s = {bus.dot[i], (bus.en[i] ? seg_enc(bus.data_text[4*i +: 4]) : 7'h00)};
            end
            seg_frame_s[8*i +: 8] = (bus.blink[i] && !blink_ph_r) ? 8'h00 : tube_s;
        end
    end

    // Transfer FSM next state plus slot/phase sequencing.
    always_comb begin
        nxt_state_s = state_r;
        nxt_ph_s    = ph_r;
        nxt_slot_s  = slot_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s || pend_r) begin
                    nxt_state_s = ST_LOAD;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                nxt_state_s = ST_SHIFT;
                nxt_ph_s    = '0;
                nxt_slot_s  = '0;
            end
            ST_SHIFT: begin
                if (ph_r == PH_LAST) begin
                    nxt_ph_s = '0;
                    if (slot_r == SLOT_LAST) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_slot_s = slot_r + SLOT_W'(1);
                    end
                end else begin
                    nxt_ph_s = ph_r + PH_W'(1);
                end
            end
            ST_DONE: nxt_state_s = ST_IDLE;
            default: nxt_state_s = ST_IDLE;
        endcase
    end

    // State, counters and status flags; status follows the next state so it lines up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ph_r    <= '0;
            slot_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            ph_r    <= nxt_ph_s;
            slot_r  <= nxt_slot_s;
            busy_r  <= (nxt_state_s != ST_IDLE);
            done_r  <= (nxt_state_s == ST_DONE);
        end
    end

    disp_shift_chan #(.LEN(SEG_BITS), .INVERT(SEG_INVERT), .SW(SLOT_W)) u_seg_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .frame      (seg_frame_s),
        .slot_adv   (slot_adv_s),
        .nxt_slot   (nxt_slot_s),
        .shift_nxt  (shift_nxt_s),
        .clk_hi_nxt (clk_hi_nxt_s),
        .sclk       (seg_clk_s),
        .sdo        (seg_do_s),
        .soe        (seg_en_s)
    );

    disp_shift_chan #(.LEN(LED_BITS), .INVERT(LED_INVERT), .SW(SLOT_W)) u_led_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .frame      (bus.led),
        .slot_adv   (slot_adv_s),
        .nxt_slot   (nxt_slot_s),
        .shift_nxt  (shift_nxt_s),
        .clk_hi_nxt (clk_hi_nxt_s),
        .sclk       (led_clk_s),
        .sdo        (led_do_s),
        .soe        (led_en_s)
    );

    assign bus.busy       = busy_r;
    assign bus.frame_done = done_r;
    assign bus.seg_clk    = seg_clk_s;
    assign bus.seg_do     = seg_do_s;
    assign bus.seg_en     = seg_en_s;
    assign bus.led_clk    = led_clk_s;
    assign bus.led_do     = led_do_s;
    assign bus.led_en     = led_en_s;
endmodule

// File: tb/tb_board_disp_serial.sv
// Directed bench: two drivers (plain and segment-inverted) share one stimulus;
// serial streams are reassembled on rising channel clocks and compared to hand values.
module tb_board_disp_serial;
    localparam int DIGITS = 2, LED_BITS = 4, SCLK_DIV = 4, REFRESH_CYCLES = 200, BLINK_TICKS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  en_v = 2'b00, dot_v = 2'b00, blink_v = 2'b00;
    logic        mode_v = 1'b0, force_v = 1'b0;
    logic [7:0]  text_v = 8'h00;
    logic [15:0] gr_v = 16'h0000;
    logic [3:0]  led_v = 4'h0;

    board_disp_serial_if #(.DIGITS(DIGITS), .LED_BITS(LED_BITS)) ifa ();
    board_disp_serial_if #(.DIGITS(DIGITS), .LED_BITS(LED_BITS)) ifb ();

    assign ifa.en = en_v;  assign ifa.mode = mode_v; assign ifa.data_text = text_v;
    assign ifa.data_graphic = gr_v; assign ifa.dot = dot_v; assign ifa.blink = blink_v;
    assign ifa.led = led_v; assign ifa.force_req = force_v;
    assign ifb.en = en_v;  assign ifb.mode = mode_v; assign ifb.data_text = text_v;
    assign ifb.data_graphic = gr_v; assign ifb.dot = dot_v; assign ifb.blink = blink_v;
    assign ifb.led = led_v; assign ifb.force_req = force_v;

    board_disp_serial #(.DIGITS(DIGITS), .LED_BITS(LED_BITS), .SCLK_DIV(SCLK_DIV),
        .REFRESH_CYCLES(REFRESH_CYCLES), .BLINK_TICKS(BLINK_TICKS),
        .SEG_INVERT(1'b0), .LED_INVERT(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    board_disp_serial #(.DIGITS(DIGITS), .LED_BITS(LED_BITS), .SCLK_DIV(SCLK_DIV),
        .REFRESH_CYCLES(REFRESH_CYCLES), .BLINK_TICKS(BLINK_TICKS),
        .SEG_INVERT(1'b1), .LED_INVERT(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_checks = 0, n_err = 0;
    int cyc = 0;
    logic [15:0] cap_seg_a = '0, cap_seg_b = '0;
    logic [3:0]  cap_led = '0;
    int n_seg = 0, n_led = 0, n_frames = 0, n_done = 0;
    int first_rise = -1, load_cyc = 0, idle_start = 0, last_gap = -1, done_at = 0;
    logic sclk_a_q = 1'b0, sclk_b_q = 1'b0, lclk_q = 1'b0, busy_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle count for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Reassemble serial streams and track frame boundaries away from the active edge.
    always @(negedge clk) begin
        if (ifa.seg_clk && !sclk_a_q) begin
            cap_seg_a = {cap_seg_a[14:0], ifa.seg_do};
            n_seg++;
            if (first_rise < 0) first_rise = cyc;
        end
        if (ifb.seg_clk && !sclk_b_q) cap_seg_b = {cap_seg_b[14:0], ifb.seg_do};
        if (ifa.led_clk && !lclk_q) begin
            cap_led = {cap_led[2:0], ifa.led_do};
            n_led++;
        end
        if (ifa.busy && !busy_q) begin
            n_frames++;
            load_cyc = cyc;
            last_gap = cyc - idle_start;
        end
        if (!ifa.busy && busy_q) idle_start = cyc;
        if (ifa.frame_done) n_done++;
        sclk_a_q = ifa.seg_clk; sclk_b_q = ifb.seg_clk; lclk_q = ifa.led_clk; busy_q = ifa.busy;
    end

    task automatic clear_caps();
        @(posedge clk);
        cap_seg_a = '0; cap_seg_b = '0; cap_led = '0;
        n_seg = 0; n_led = 0; n_frames = 0; n_done = 0; first_rise = -1; last_gap = -1;
    endtask

    task automatic wait_busy(input string tag, output int n);
        logic ok;
        n = 0; ok = 1'b0;
        while (n < 400 && !ok) begin
            @(negedge clk);
            n++;
            ok = ifa.busy;
        end
        check({tag, "_busy_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        logic ok;
        n = 0; ok = 1'b0;
        while (n < 400 && !ok) begin
            @(negedge clk);
            n++;
            ok = ifa.frame_done;
        end
        done_at = cyc;
        check({tag, "_done_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic force_pulse();
        @(negedge clk); force_v = 1'b1;
        @(negedge clk); force_v = 1'b0;
    endtask

    // Let the next refresh-tick frame finish so a forced frame fits before the following tick.
    task automatic sync_tick(input string tag);
        int n;
        wait_busy(tag, n);
        wait_done(tag);
        clear_caps();
    endtask

    task automatic outs_a(output logic [7:0] v);
        v = {ifa.busy, ifa.frame_done, ifa.led_clk, ifa.led_do, ifa.led_en,
             ifa.seg_clk, ifa.seg_do, ifa.seg_en};
    endtask

    initial begin
        logic [7:0] ov;
        int n;
        logic [15:0] blink_exp [4];
        blink_exp[0] = 16'h065B; blink_exp[1] = 16'h0600;
        blink_exp[2] = 16'h0600; blink_exp[3] = 16'h065B;

        repeat (3) @(negedge clk);
        outs_a(ov);
        check("reset_outputs", {24'd0, ov}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_en_busy", {29'd0, ifa.led_en, ifa.seg_en, ifa.busy}, {29'd0, 3'b110});

        // Text frame: tube1 '3'+dot -> CF, tube0 'A' -> 77.
        mode_v = 1'b0; text_v = 8'h3A; en_v = 2'b11; dot_v = 2'b10; led_v = 4'b1010;
        sync_tick("text_sync");
        force_pulse();
        wait_done("text");
        check("text_seg", {16'd0, cap_seg_a}, 32'h0000CF77);
        check("text_seg_inv", {16'd0, cap_seg_b}, 32'h00003088);
        check("text_seg_edges", n_seg, 32'd16);
        check("led_bits", {28'd0, cap_led}, 32'hA);
        check("led_edges", n_led, 32'd4);
        check("frame_len", done_at - load_cyc + 1, 32'd66);
        check("first_sclk_rise", first_rise - load_cyc, 32'd3);
        check("seg_do_hold", {31'd0, ifa.seg_do}, 32'd1);
        check("led_do_hold", {31'd0, ifa.led_do}, 32'd0);

        // Graphic mode with tube1 disabled.
        mode_v = 1'b1; en_v = 2'b01; gr_v = 16'hFFAA;
        sync_tick("gfx_sync");
        force_pulse();
        wait_done("gfx");
        check("gfx_seg", {16'd0, cap_seg_a}, 32'h000000AA);
        check("gfx_seg_inv", {16'd0, cap_seg_b}, 32'h0000FF55);

        // Two forces and a refresh tick inside one frame yield one extra frame.
        mode_v = 1'b0; en_v = 2'b11; dot_v = 2'b00;
        sync_tick("coll_sync");
        repeat (95) @(negedge clk);
        force_pulse();
        repeat (10) @(negedge clk);
        force_pulse();
        repeat (10) @(negedge clk);
        force_pulse();
        repeat (150) @(negedge clk);
        check("coll_frames", n_frames, 32'd2);
        check("coll_done", n_done, 32'd2);
        check("coll_gap", last_gap, 32'd1);

        // Reset in the middle of a high serial clock phase.
        force_pulse();
        n = 0;
        while (n < 100 && !ifa.seg_clk) begin
            @(negedge clk);
            n++;
        end
        check("mid_sclk_high", {31'd0, ifa.seg_clk}, 32'd1);
        check("mid_en_busy", {29'd0, ifa.busy, ifa.seg_en, ifa.led_en}, {29'd0, 3'b100});
        rst_n = 1'b0;
        #1;
        outs_a(ov);
        check("async_reset_outputs", {24'd0, ov}, 32'd0);
        mode_v = 1'b0; text_v = 8'h12; en_v = 2'b11; dot_v = 2'b00; blink_v = 2'b01;
        repeat (2) @(negedge clk);
        clear_caps();
        @(negedge clk);
        rst_n = 1'b1;
        wait_busy("post_reset", n);
        check("post_reset_first_frame", n, 32'd200);

        // Blink: tube0 visible, blank, blank, visible over four tick frames.
        for (int f = 0; f < 4; f++) begin
            if (f > 0) begin
                clear_caps();
                wait_busy("blink", n);
            end
            wait_done("blink");
            check($sformatf("blink_frame%0d", f), {16'd0, cap_seg_a}, {16'd0, blink_exp[f]});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
